// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter.
// Each requester keeps the grant for ew(k) = max(weight[k], 1) trigger cycles
// while it keeps requesting; lock stretches a grant indefinitely without
// consuming credit. Grant, index and valid are all registered.
module wrr_arbiter #(
    parameter int nReq    = 16,
    parameter int WeightW = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       trigger,
    input  logic [nReq-1:0]            request,
    input  logic [nReq*WeightW-1:0]    weight,
    input  logic                       lock,
    output logic [nReq-1:0]            grant,
    output logic [$clog2(nReq)-1:0]    grant_id,
    output logic                       grant_valid
);

    localparam int IdW = $clog2(nReq);
    // Modulus used to wrap the rotating scan, sized one bit wider than an index.
    localparam logic [IdW:0]   NREQ_W   = (IdW+1)'(nReq);
    localparam logic [IdW-1:0] LAST_IDX = IdW'(nReq - 1);

    generate
        if (nReq < 2) begin : g_bad_nreq
            $error("wrr_arbiter: nReq must be at least 2");
        end
        if (WeightW < 1) begin : g_bad_weightw
            $error("wrr_arbiter: WeightW must be at least 1");
        end
    endgenerate

    // Unpack the flat weight bus into one field per requester.
    logic [WeightW-1:0] weight_arr [nReq];

    generate
        for (genvar gi = 0; gi < nReq; gi++) begin : g_weight
            assign weight_arr[gi] = weight[gi*WeightW +: WeightW];
        end
    endgenerate

    logic [nReq-1:0]    grant_q,       grant_d;
    logic [IdW-1:0]     grant_id_q,    grant_id_d;
    logic               grant_valid_q, grant_valid_d;
    logic [WeightW-1:0] credit_q,      credit_d;
    logic [IdW-1:0]     ptr_q,         ptr_d;

    // Scan helpers: first requester found starting at ptr, wrapping around.
    logic               hold_now;
    logic               found;
    logic [IdW-1:0]     sel;
    logic [IdW:0]       scan_sum;
    logic [IdW-1:0]     scan_idx;
    logic [WeightW-1:0] sel_weight;

    // Next-state: hold the current owner, re-arbitrate, or go idle.
    always_comb begin
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        credit_d      = credit_q;
        ptr_d         = ptr_q;
        found         = 1'b0;
        sel           = '0;
        scan_sum      = '0;
        scan_idx      = '0;
        sel_weight    = '0;
        hold_now      = grant_valid_q && request[grant_id_q] &&
                        (lock || (credit_q != '0));

        // Rotating priority search, lowest offset from ptr wins.
        for (int i = 0; i < nReq; i++) begin
            scan_sum = {1'b0, ptr_q} + (IdW+1)'(i);
            if (scan_sum >= NREQ_W) begin
                scan_sum = scan_sum - NREQ_W;
            end
            scan_idx = scan_sum[IdW-1:0];
            if (!found && request[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
        sel_weight = weight_arr[sel];

        if (trigger) begin
            if (hold_now) begin
                // Locked grants keep their credit frozen.
                if (!lock) begin
                    credit_d = credit_q - WeightW'(1);
                end
            end else if (found) begin
                grant_d       = '0;
                grant_d[sel]  = 1'b1;
                grant_id_d    = sel;
                grant_valid_d = 1'b1;
                // A zero weight behaves as weight one: a single beat.
                credit_d      = (sel_weight == '0) ? '0 : sel_weight - WeightW'(1);
                ptr_d         = (sel == LAST_IDX) ? '0 : sel + IdW'(1);
            end else begin
                // Nobody asking: drop the grant, keep index, credit and pointer.
                grant_d       = '0;
                grant_valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            credit_q      <= '0;
            ptr_q         <= '0;
        end else begin
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            credit_q      <= credit_d;
            ptr_q         <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Testbench for wrr_arbiter: directed scenarios followed by random traffic,
// all compared against a behavioural model of the weighted round-robin rules.
module tb_wrr_arbiter;

    localparam int NREQ = 16;
    localparam int WW   = 4;

    logic              clock;
    logic              reset;
    logic              trigger;
    logic [NREQ-1:0]   request;
    logic [NREQ*WW-1:0] weight;
    logic              lock;
    logic [NREQ-1:0]   grant;
    logic [3:0]        grant_id;
    logic              grant_valid;

    int checks;
    int errors;

    // Reference model state: current owner, beats it still has left, search start.
    bit m_valid;
    int m_id;
    int m_left;
    int m_ptr;

    wrr_arbiter #(.nReq(NREQ), .WeightW(WW)) dut (
        .clock       (clock),
        .reset       (reset),
        .trigger     (trigger),
        .request     (request),
        .weight      (weight),
        .lock        (lock),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit req_bit(int k);
        return ((request >> k) & 16'h1) != 16'h0;
    endfunction

    function automatic int eff_weight(int k);
        int w;
        w = int'((weight >> (WW * k)) & 64'hF);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_id    = 0;
        m_left  = 0;
        m_ptr   = 0;
    endtask

    // One trigger cycle of the arbitration rules, using the inputs at this edge.
    task automatic model_step();
        bit got;
        if (!trigger) return;
        if (m_valid && req_bit(m_id) && (lock || m_left != 0)) begin
            if (!lock) m_left = m_left - 1;
        end else begin
            got = 1'b0;
            for (int j = 0; j < NREQ; j++) begin
                int k;
                k = (m_ptr + j) % NREQ;
                if (!got && req_bit(k)) begin
                    got     = 1'b1;
                    m_valid = 1'b1;
                    m_id    = k;
                    m_left  = eff_weight(k) - 1;
                    m_ptr   = (k + 1) % NREQ;
                end
            end
            if (!got) m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs(string tag);
        logic [NREQ-1:0] eg;
        logic [3:0]      eid;
        eg  = m_valid ? (16'd1 << m_id) : 16'd0;
        eid = 4'(m_id);
        checks++;
        assert (grant === eg) else begin
            errors++;
            $error("FAIL %s grant observed=%h expected=%h", tag, grant, eg);
        end
        checks++;
        assert (grant_id === eid) else begin
            errors++;
            $error("FAIL %s grant_id observed=%0d expected=%0d", tag, grant_id, eid);
        end
        checks++;
        assert (grant_valid === m_valid) else begin
            errors++;
            $error("FAIL %s grant_valid observed=%b expected=%b", tag, grant_valid, m_valid);
        end
        checks++;
        assert ((grant_valid === (|grant)) && $onehot0(grant)) else begin
            errors++;
            $error("FAIL %s onehot grant=%h valid=%b required one-hot/zero with valid==|grant",
                   tag, grant, grant_valid);
        end
        $display("%-8s t=%0t trig=%b req=%h lock=%b -> grant=%h id=%0d valid=%b",
                 tag, $time, trigger, request, lock, grant, grant_id, grant_valid);
    endtask

    // Advance one clock: model follows the edge, outputs sampled 1 ns later.
    task automatic step(string tag);
        @(posedge clock);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    task automatic sync_reset_pulse();
        reset = 1'b1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_id(string tag, int exp_id);
        checks++;
        assert (grant_valid === 1'b1 && grant_id === 4'(exp_id)) else begin
            errors++;
            $error("FAIL %s seq observed=%0d/%b expected=%0d/1", tag, grant_id, grant_valid, exp_id);
        end
    endtask

    initial begin
        int seq2 [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int budget;
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        trigger = 1'b0;
        request = '0;
        weight  = '0;
        lock    = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outputs("reset");
        reset = 1'b0;

        // 1: everyone requesting, unit weights -> plain rotation.
        trigger = 1'b1;
        request = 16'hFFFF;
        weight  = {16{4'h1}};
        for (int i = 0; i < 17; i++) begin
            step("rot");
            check_id("rot", i % 16);
        end

        // 2: weight 3 against weight 1.
        sync_reset_pulse();
        request = 16'h0003;
        weight  = {{14{4'h1}}, 4'h1, 4'h3};
        for (int i = 0; i < 8; i++) begin
            step("wt31");
            check_id("wt31", seq2[i]);
        end

        // 3: lock holds requester 2 past its credit.
        sync_reset_pulse();
        request = 16'h000C;
        weight  = {16{4'h1}};
        budget  = 0;
        do begin
            step("lkwait");
            budget++;
        end while (!(grant_valid === 1'b1 && grant_id === 4'd2) && budget < 20);
        checks++;
        assert (budget < 20) else begin
            errors++;
            $error("FAIL lkwait timeout observed=%0d cycles required<20", budget);
        end
        lock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("lock");
            check_id("lock", 2);
        end
        lock = 1'b0;
        step("unlock");
        check_id("unlock", 3);

        // 4: heavy holder drops its request early, then everyone goes quiet.
        sync_reset_pulse();
        request = 16'h0003;
        weight  = {{15{4'h1}}, 4'h8};
        step("drop");
        step("drop");
        request = 16'h0002;
        step("drop");
        check_id("drop", 1);
        request = 16'h0000;
        step("idle");
        step("idle");

        // 5: freeze mid-grant, then asynchronous reset mid-cycle.
        request = 16'h00F0;
        weight  = {16{4'h2}};
        step("pre");
        step("pre");
        trigger = 1'b0;
        request = 16'h0F0F;
        lock    = 1'b1;
        for (int i = 0; i < 10; i++) step("freeze");
        lock    = 1'b0;
        trigger = 1'b1;
        request = 16'h00F0;
        step("resume");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs("areset");
        #1;
        reset   = 1'b0;
        request = 16'hFFFF;
        step("postrst");
        check_id("postrst", 0);

        // 6: zero weight behaves as one; sole requester re-granted every cycle.
        request = 16'h0020;
        weight  = {{10{4'h3}}, 4'h0, {5{4'h3}}};
        for (int i = 0; i < 4; i++) begin
            step("zerow");
            check_id("zerow", 5);
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            trigger = ($urandom_range(0, 9) != 0);
            request = (i % 3 == 0) ? 16'($urandom) : (16'($urandom) & 16'($urandom));
            if ($urandom_range(0, 15) == 0) request = '0;
            if ($urandom_range(0, 7) == 0) weight = {$urandom, $urandom};
            lock = ($urandom_range(0, 4) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
